ifft_cmul_arbiter: RTL and testbench
====================================

Name: ifft_cmul_arbiter

Overview:
- Shares the single 16-bit fixed-point IFFT complex multiplier between two requesters, for example butterfly stage A and stage B twiddle paths.
- Arbitrates the requesters round-robin with valid/ready handshakes.
- Drives the multiplier operand bus and registers each product into a per-requester response slot with backpressure.
- Sits between the butterfly stage controllers and the combinational complex multiplier instance.

Parameters:
- DATA_W, 16, width of every real/imag operand and result (Q5.10: 1.0 = 0x0400).
- INIT_LAST, 1, value of last_grant after reset. Default 1 means requester 0 wins the first tie.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  reset. Synchronous, active-low.
- req0_valid  input  1  requester 0 holds a valid operand pair.
- req0_ready  output  1  requester 0 granted this cycle; the operand pair is consumed.
- req0_op1_real, req0_op1_imag, req0_op2_real, req0_op2_imag  input  DATA_W each  requester 0 operands, signed.
- req1_valid, req1_ready, req1_op1_real, req1_op1_imag, req1_op2_real, req1_op2_imag  as requester 0, for requester 1.
- mul_op_1_real, mul_op_1_imag, mul_op_2_real, mul_op_2_imag  output  DATA_W each  operands to the shared multiplier.
- mul_result_real, mul_result_imag  input  DATA_W each  combinational product returned by the multiplier.
- rsp0_valid  output  1  response slot 0 is full.
- rsp0_ready  input  1  requester 0 accepts its response.
- rsp0_real, rsp0_imag  output  DATA_W each  registered product for requester 0.
- rsp1_valid, rsp1_ready, rsp1_real, rsp1_imag  as response channel 0, for requester 1.
- last_grant  output  1  index of the most recently granted requester.

Behaviour:
- Eligibility: elig_i = req_i_valid && (!rsp_i_valid || rsp_i_ready). A full slot being drained in the same cycle counts as free.
- Grant, combinational:
  - Only one requester eligible: it is granted.
  - Both eligible: grant goes to the requester != last_grant.
  - Neither eligible: no grant.
  - At most one reqN_ready is high per cycle.
  - reqN_ready = grant_N. It never asserts without the matching reqN_valid.
- Operand mux, combinational: mul_op_* carries the granted requester's operands. With no grant, all mul_op_* = 0.
- Capture at the rising edge with a grant to i:
  - rsp_i_real/imag <= mul_result_real/imag.
  - rsp_i_valid <= 1.
  - last_grant <= i.
- Latency: the product appears on rspN outputs exactly 1 cycle after reqN_valid && reqN_ready.
- Throughput: 1 product per cycle in aggregate. One requester with rsp_ready held high also reaches 1 per cycle.
- Drain: rsp_i_valid && rsp_i_ready with no new grant to i gives rsp_i_valid <= 0 next edge. Data is held, not cleared.
- Simultaneous drain and grant to the same slot: valid stays 1 and data is replaced by the new product. No bubble.
- Backpressure: while rsp_i_valid && !rsp_i_ready, requester i is never granted. The other requester proceeds unaffected.
- Stability: rspN_real/imag and rspN_valid hold while valid is high and ready is low.
- last_grant changes only on a grant. Idle cycles leave it unchanged.
- Arithmetic: the block performs no arithmetic. Widths pass through; sign is preserved by wiring.
- Reset (rst_n == 0 at a rising edge, including mid-transfer):
  - rsp0_valid = rsp1_valid = 0.
  - rsp*_real/imag = 0.
  - last_grant = INIT_LAST.
  - reqN_ready is forced to 0 and mul_op_* to 0 while rst_n is low.
  - Pending responses are discarded.
- No other state exists; the block has no FSM beyond the two slot-valid flags and the last_grant bit.

Test Plan:
- Single product: req0 op1=(0x0400,0x0000), op2=(0x0200,0x0200), rsp0_ready=1. Expect req0_ready=1 in cycle T; rsp0_valid=1 with (0x0200,0x0200) in T+1; last_grant=0.
- Round-robin: both valid for 4 cycles, both rsp_ready=1, after reset. Expect grants 0,1,0,1; each rspN_valid pulses on alternating cycles with the correct products.
- Backpressure: rsp0 full, rsp0_ready=0, both req valid for 3 cycles. Expect req0_ready=0 throughout, req1 granted every cycle, rsp0 data stable.
- Drain-and-refill: rsp0 full, rsp0_ready=1, req0 only valid with op1=(0xFC00,0), op2=(0x0400,0). Expect a same-cycle grant and rsp0_valid staying 1, now (0xFC00,0x0000).
- Idle: no valid inputs. Expect mul_op_*=0, no ready, and last_grant unchanged over 5 cycles.
- Reset mid-operation: rst_n=0 for 1 edge while rsp1_valid=1 and both requests valid. Expect next cycle rsp*_valid=0, outputs 0, last_grant=1, then requester 0 granted first once rst_n=1.

Source files
------------

// File: rtl/ifft_cmul_arbiter.sv
// rtl/ifft_cmul_arbiter.sv - round-robin share of one complex multiplier between two requesters
module ifft_cmul_arbiter #(
  parameter int DATA_W    = 16,
  parameter bit INIT_LAST = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [DATA_W-1:0] req0_op1_real,
  input  logic [DATA_W-1:0] req0_op1_imag,
  input  logic [DATA_W-1:0] req0_op2_real,
  input  logic [DATA_W-1:0] req0_op2_imag,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [DATA_W-1:0] req1_op1_real,
  input  logic [DATA_W-1:0] req1_op1_imag,
  input  logic [DATA_W-1:0] req1_op2_real,
  input  logic [DATA_W-1:0] req1_op2_imag,
  output logic [DATA_W-1:0] mul_op_1_real,
  output logic [DATA_W-1:0] mul_op_1_imag,
  output logic [DATA_W-1:0] mul_op_2_real,
  output logic [DATA_W-1:0] mul_op_2_imag,
  input  logic [DATA_W-1:0] mul_result_real,
  input  logic [DATA_W-1:0] mul_result_imag,
  output logic              rsp0_valid,
  input  logic              rsp0_ready,
  output logic [DATA_W-1:0] rsp0_real,
  output logic [DATA_W-1:0] rsp0_imag,
  output logic              rsp1_valid,
  input  logic              rsp1_ready,
  output logic [DATA_W-1:0] rsp1_real,
  output logic [DATA_W-1:0] rsp1_imag,
  output logic              last_grant
);

  logic elig0, elig1, grant0, grant1;

  // A slot being drained this cycle can accept the next product without a bubble.
  assign elig0  = req0_valid && (!rsp0_valid || rsp0_ready);
  assign elig1  = req1_valid && (!rsp1_valid || rsp1_ready);
  assign grant0 = rst_n && elig0 && (!elig1 || last_grant);
  assign grant1 = rst_n && elig1 && (!elig0 || !last_grant);

  assign req0_ready = grant0;
  assign req1_ready = grant1;

  always_comb begin
    mul_op_1_real = '0;
    mul_op_1_imag = '0;
    mul_op_2_real = '0;
    mul_op_2_imag = '0;
    if (grant0) begin
      mul_op_1_real = req0_op1_real;
      mul_op_1_imag = req0_op1_imag;
      mul_op_2_real = req0_op2_real;
      mul_op_2_imag = req0_op2_imag;
    end else if (grant1) begin
      mul_op_1_real = req1_op1_real;
      mul_op_1_imag = req1_op1_imag;
      mul_op_2_real = req1_op2_real;
      mul_op_2_imag = req1_op2_imag;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rsp0_valid <= 1'b0;
      rsp0_real  <= '0;
      rsp0_imag  <= '0;
      rsp1_valid <= 1'b0;
      rsp1_real  <= '0;
      rsp1_imag  <= '0;
      last_grant <= INIT_LAST;
    end else begin
      if (grant0) begin
        rsp0_valid <= 1'b1;
        rsp0_real  <= mul_result_real;
        rsp0_imag  <= mul_result_imag;
        last_grant <= 1'b0;
      end else if (rsp0_ready) begin
        rsp0_valid <= 1'b0;
      end
      if (grant1) begin
        rsp1_valid <= 1'b1;
        rsp1_real  <= mul_result_real;
        rsp1_imag  <= mul_result_imag;
        last_grant <= 1'b1;
      end else if (rsp1_ready) begin
        rsp1_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ifft_cmul_arbiter.sv
// tb/tb_ifft_cmul_arbiter.sv - directed scoreboard bench for ifft_cmul_arbiter
module tb_ifft_cmul_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0_valid, req0_ready, req1_valid, req1_ready;
  logic [15:0] req0_op1_real, req0_op1_imag, req0_op2_real, req0_op2_imag;
  logic [15:0] req1_op1_real, req1_op1_imag, req1_op2_real, req1_op2_imag;
  logic [15:0] mul_op_1_real, mul_op_1_imag, mul_op_2_real, mul_op_2_imag;
  logic [15:0] mul_result_real, mul_result_imag;
  logic        rsp0_valid, rsp0_ready, rsp1_valid, rsp1_ready;
  logic [15:0] rsp0_real, rsp0_imag, rsp1_real, rsp1_imag;
  logic        last_grant;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] q0[$];
  logic [31:0] q1[$];
  logic        ev0, ev1, elg;
  logic [31:0] ed0, ed1;

  always #5 clk = ~clk;

  // Q5.10 complex product, standing in for the shared multiplier instance.
  function automatic logic [31:0] cmul(input logic [15:0] ar, input logic [15:0] ai,
                                       input logic [15:0] br, input logic [15:0] bi);
    int sar, sai, sbr, sbi, re, im;
    sar = $signed(ar);
    sai = $signed(ai);
    sbr = $signed(br);
    sbi = $signed(bi);
    re  = (sar * sbr - sai * sbi) >>> 10;
    im  = (sar * sbi + sai * sbr) >>> 10;
    return {re[15:0], im[15:0]};
  endfunction

  assign {mul_result_real, mul_result_imag} =
    cmul(mul_op_1_real, mul_op_1_imag, mul_op_2_real, mul_op_2_imag);

  ifft_cmul_arbiter #(.DATA_W(16), .INIT_LAST(1'b1)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_op1_real(req0_op1_real), .req0_op1_imag(req0_op1_imag),
    .req0_op2_real(req0_op2_real), .req0_op2_imag(req0_op2_imag),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_op1_real(req1_op1_real), .req1_op1_imag(req1_op1_imag),
    .req1_op2_real(req1_op2_real), .req1_op2_imag(req1_op2_imag),
    .mul_op_1_real(mul_op_1_real), .mul_op_1_imag(mul_op_1_imag),
    .mul_op_2_real(mul_op_2_real), .mul_op_2_imag(mul_op_2_imag),
    .mul_result_real(mul_result_real), .mul_result_imag(mul_result_imag),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
    .rsp0_real(rsp0_real), .rsp0_imag(rsp0_imag),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
    .rsp1_real(rsp1_real), .rsp1_imag(rsp1_imag),
    .last_grant(last_grant)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic set_ops0(input logic [15:0] a, input logic [15:0] b,
                          input logic [15:0] c, input logic [15:0] d);
    req0_op1_real = a; req0_op1_imag = b; req0_op2_real = c; req0_op2_imag = d;
  endtask

  task automatic set_ops1(input logic [15:0] a, input logic [15:0] b,
                          input logic [15:0] c, input logic [15:0] d);
    req1_op1_real = a; req1_op1_imag = b; req1_op2_real = c; req1_op2_imag = d;
  endtask

  task automatic rand_ops();
    logic [31:0] r0, r1, r2, r3;
    r0 = $urandom; r1 = $urandom; r2 = $urandom; r3 = $urandom;
    set_ops0(r0[15:0], r0[31:16], r1[15:0], r1[31:16]);
    set_ops1(r2[15:0], r2[31:16], r3[15:0], r3[31:16]);
  endtask

  // One clock: check grants and operand bus mid-cycle, then the registered slots after the edge.
  task automatic cycle(input string tag, input logic e0, input logic e1);
    logic [31:0] x1, x2;
    logic        rstl, rdy0, rdy1;
    @(negedge clk);
    rstl = rst_n;
    rdy0 = rsp0_ready;
    rdy1 = rsp1_ready;
    x1 = 32'h0;
    x2 = 32'h0;
    if (e0) begin
      x1 = {req0_op1_real, req0_op1_imag};
      x2 = {req0_op2_real, req0_op2_imag};
      q0.push_back(cmul(req0_op1_real, req0_op1_imag, req0_op2_real, req0_op2_imag));
    end else if (e1) begin
      x1 = {req1_op1_real, req1_op1_imag};
      x2 = {req1_op2_real, req1_op2_imag};
      q1.push_back(cmul(req1_op1_real, req1_op1_imag, req1_op2_real, req1_op2_imag));
    end
    chk({tag, ":req0_ready"}, {31'd0, req0_ready}, {31'd0, e0});
    chk({tag, ":req1_ready"}, {31'd0, req1_ready}, {31'd0, e1});
    chk({tag, ":mul_op_1"}, {mul_op_1_real, mul_op_1_imag}, x1);
    chk({tag, ":mul_op_2"}, {mul_op_2_real, mul_op_2_imag}, x2);
    @(posedge clk);
    #1;
    if (!rstl) begin
      ev0 = 1'b0; ev1 = 1'b0; ed0 = 32'h0; ed1 = 32'h0; elg = 1'b1;
      q0.delete();
      q1.delete();
    end else begin
      if (e0) begin ed0 = q0.pop_front(); ev0 = 1'b1; elg = 1'b0; end
      else if (rdy0) ev0 = 1'b0;
      if (e1) begin ed1 = q1.pop_front(); ev1 = 1'b1; elg = 1'b1; end
      else if (rdy1) ev1 = 1'b0;
    end
    chk({tag, ":rsp0_valid"}, {31'd0, rsp0_valid}, {31'd0, ev0});
    chk({tag, ":rsp0_data"}, {rsp0_real, rsp0_imag}, ed0);
    chk({tag, ":rsp1_valid"}, {31'd0, rsp1_valid}, {31'd0, ev1});
    chk({tag, ":rsp1_data"}, {rsp1_real, rsp1_imag}, ed1);
    chk({tag, ":last_grant"}, {31'd0, last_grant}, {31'd0, elg});
  endtask

  initial begin
    ev0 = 1'b0; ev1 = 1'b0; ed0 = 32'h0; ed1 = 32'h0; elg = 1'b1;
    rst_n = 1'b0;
    req0_valid = 1'b1; req1_valid = 1'b0;
    rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    set_ops0(16'h0400, 16'h0000, 16'h0200, 16'h0200);
    set_ops1(16'h0000, 16'h0000, 16'h0000, 16'h0000);
    cycle("reset_a", 1'b0, 1'b0);
    cycle("reset_b", 1'b0, 1'b0);

    rst_n = 1'b1;
    cycle("single", 1'b1, 1'b0);
    chk("single:product", {rsp0_real, rsp0_imag}, 32'h0200_0200);
    req0_valid = 1'b0;
    cycle("single_drain", 1'b0, 1'b0);

    rst_n = 1'b0;
    cycle("rr_reset", 1'b0, 1'b0);
    rst_n = 1'b1;
    req0_valid = 1'b1; req1_valid = 1'b1;
    rand_ops(); cycle("rr0", 1'b1, 1'b0);
    rand_ops(); cycle("rr1", 1'b0, 1'b1);
    rand_ops(); cycle("rr2", 1'b1, 1'b0);
    rand_ops(); cycle("rr3", 1'b0, 1'b1);

    req1_valid = 1'b0; rsp0_ready = 1'b0;
    rand_ops(); cycle("bp_fill", 1'b1, 1'b0);
    req1_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      rand_ops();
      cycle("backpressure", 1'b0, 1'b1);
    end

    req1_valid = 1'b0; rsp0_ready = 1'b1;
    set_ops0(16'hFC00, 16'h0000, 16'h0400, 16'h0000);
    cycle("refill", 1'b1, 1'b0);
    chk("refill:product", {rsp0_real, rsp0_imag}, 32'hFC00_0000);

    req0_valid = 1'b0;
    for (int i = 0; i < 5; i++) cycle("idle", 1'b0, 1'b0);

    req1_valid = 1'b1; rsp1_ready = 1'b0;
    rand_ops(); cycle("mid_fill", 1'b0, 1'b1);
    req0_valid = 1'b1; rsp0_ready = 1'b0;
    rst_n = 1'b0;
    cycle("mid_reset", 1'b0, 1'b0);
    rst_n = 1'b1; rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    rand_ops(); cycle("post_reset0", 1'b1, 1'b0);
    rand_ops(); cycle("post_reset1", 1'b0, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
